// File: rtl/convolutor_pkg.sv
// Shared types and constants for the convolutor index generator.
package convolutor_pkg;

    localparam int ADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SIZED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } idx_state_t;

    // Vector length as seen on the size ports (ADDR_W+1 bits at the default width).
    typedef logic [ADDR_W_DEF:0] size_t;

endpackage

// File: rtl/convolutor_index_gen_if.sv
// Stage-pulse / decision-flag / address bundle between the convolutor FSM and the index generator.
interface convolutor_index_gen_if
    import convolutor_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              register_load_i;
    logic [ADDR_W:0]   size_x_i;
    logic [ADDR_W:0]   size_y_i;
    logic              diag_size_i;
    logic              half_loop_load_i;
    logic              iteration_count_i;
    logic              diagonal_count_i;
    logic              half_loop_o;
    logic              bounds_valid_o;
    logic              calc_complete_o;
    logic [ADDR_W-1:0] x_addr_o;
    logic [ADDR_W-1:0] y_addr_o;
    logic [ADDR_W:0]   z_addr_o;

    modport master (
        output register_load_i, size_x_i, size_y_i, diag_size_i,
               half_loop_load_i, iteration_count_i, diagonal_count_i,
        input  half_loop_o, bounds_valid_o, calc_complete_o,
               x_addr_o, y_addr_o, z_addr_o
    );

    modport slave (
        input  register_load_i, size_x_i, size_y_i, diag_size_i,
               half_loop_load_i, iteration_count_i, diagonal_count_i,
        output half_loop_o, bounds_valid_o, calc_complete_o,
               x_addr_o, y_addr_o, z_addr_o
    );

endinterface

// File: rtl/convolutor_bound_calc.sv
// Combinational inner-loop bounds for diagonal k: the i range with 0 <= i < Nx and 0 <= k-i < Ny.
module convolutor_bound_calc
    import convolutor_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [ADDR_W+1:0] k_i,
    input  logic [ADDR_W:0]   nx_i,
    input  logic [ADDR_W:0]   ny_i,
    output logic              half_o,
    output logic [ADDR_W+1:0] i_start_o,
    output logic [ADDR_W+1:0] i_end_o
);
    localparam int CW = ADDR_W + 2;

    logic [CW-1:0] nx_w;
    logic [CW-1:0] ny_w;
    logic [CW-1:0] nx_m1;

    assign nx_w  = CW'(nx_i);
    assign ny_w  = CW'(ny_i);
    assign nx_m1 = nx_w - CW'(1);

    assign half_o    = (k_i >= ny_w);
    assign i_start_o = half_o ? (k_i - ny_w + CW'(1)) : '0;
    assign i_end_o   = (k_i < nx_m1) ? k_i : nx_m1;

endmodule

// File: rtl/convolutor_index_gen.sv
// Index and loop-bound generator beside the convolutor FSM; produces X/Y/Z addresses and branch flags.
// Optional build macro CONVOLUTOR_SIZE_CLAMP_EN clamps loaded sizes to the memory depth 2^ADDR_W.
module convolutor_index_gen
    import convolutor_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    convolutor_index_gen_if.slave bus
);
    localparam int CW = ADDR_W + 2;

    localparam logic [1:0] S_IDLE  = 2'(IDLE);
    localparam logic [1:0] S_SIZED = 2'(SIZED);
    localparam logic [1:0] S_RUN   = 2'(RUN);
    localparam logic [1:0] S_DONE  = 2'(DONE);

    logic [1:0]    state_q, state_d;
    logic [ADDR_W:0] nx_q, nx_d;
    logic [ADDR_W:0] ny_q, ny_d;
    logic [CW-1:0] nz_q, nz_d;
    logic [CW-1:0] k_q, k_d;
    logic [CW-1:0] i_q, i_d;
    logic [CW-1:0] i_end_q, i_end_d;
    logic          loaded_q, loaded_d;

    logic [ADDR_W:0] size_x_in;
    logic [ADDR_W:0] size_y_in;
    logic [CW-1:0]   nz_calc;
    logic            half;
    logic [CW-1:0]   i_start_calc;
    logic [CW-1:0]   i_end_calc;
    logic            in_run;

`ifdef CONVOLUTOR_SIZE_CLAMP_EN
    localparam logic [ADDR_W:0] SIZE_MAX = {1'b1, {ADDR_W{1'b0}}};
    assign size_x_in = (bus.size_x_i > SIZE_MAX) ? SIZE_MAX : bus.size_x_i;
    assign size_y_in = (bus.size_y_i > SIZE_MAX) ? SIZE_MAX : bus.size_y_i;
`else
    assign size_x_in = bus.size_x_i;
    assign size_y_in = bus.size_y_i;
`endif

    // An empty vector means an empty product: Nz collapses to 0 so RUN completes at once.
    assign nz_calc = (nx_q == '0 || ny_q == '0) ? '0
                   : CW'(nx_q) + CW'(ny_q) - CW'(1);

    convolutor_bound_calc #(.ADDR_W(ADDR_W)) u_bound_calc (
        .k_i       (k_q),
        .nx_i      (nx_q),
        .ny_i      (ny_q),
        .half_o    (half),
        .i_start_o (i_start_calc),
        .i_end_o   (i_end_calc)
    );

    // NOTE: every next-state variable gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        nx_d     = nx_q;
        ny_d     = ny_q;
        nz_d     = nz_q;
        k_d      = k_q;
        i_d      = i_q;
        i_end_d  = i_end_q;
        loaded_d = loaded_q;

        if (bus.register_load_i) begin
            state_d  = S_SIZED;
            nx_d     = size_x_in;
            ny_d     = size_y_in;
            nz_d     = '0;
            k_d      = '0;
            i_d      = '0;
            i_end_d  = '0;
            loaded_d = 1'b0;
        end else begin
            case (state_q)
                S_SIZED: begin
                    if (bus.diag_size_i) begin
                        nz_d    = nz_calc;
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (k_q == nz_q) begin
                        state_d = S_DONE;
                    end else if (!bus.diag_size_i) begin
                        // Lower-priority pulses act only when no higher one is present.
                        if (bus.diagonal_count_i) begin
                            k_d      = k_q + CW'(1);
                            loaded_d = 1'b0;
                        end else if (bus.half_loop_load_i) begin
                            i_d      = i_start_calc;
                            i_end_d  = i_end_calc;
                            loaded_d = 1'b1;
                        end else if (bus.iteration_count_i) begin
                            i_d = i_q + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            nx_q     <= '0;
            ny_q     <= '0;
            nz_q     <= '0;
            k_q      <= '0;
            i_q      <= '0;
            i_end_q  <= '0;
            loaded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            nx_q     <= nx_d;
            ny_q     <= ny_d;
            nz_q     <= nz_d;
            k_q      <= k_d;
            i_q      <= i_d;
            i_end_q  <= i_end_d;
            loaded_q <= loaded_d;
        end
    end

    assign in_run = (state_q == S_RUN);

    assign bus.bounds_valid_o  = in_run && loaded_q && (i_q <= i_end_q);
    assign bus.calc_complete_o = (in_run && (k_q == nz_q)) || (state_q == S_DONE);
    assign bus.half_loop_o     = in_run && half;

    assign bus.x_addr_o = ADDR_W'(i_q);
    assign bus.y_addr_o = ADDR_W'(k_q - i_q);
    assign bus.z_addr_o = (ADDR_W+1)'(k_q);

endmodule

// File: tb/tb_convolutor_index_gen.sv
// Directed self-checking bench for convolutor_index_gen, acting as the convolutor FSM.
module tb_convolutor_index_gen;
    import convolutor_pkg::*;

    localparam logic [4:0] P_LOAD = 5'b00001;
    localparam logic [4:0] P_DSZ  = 5'b00010;
    localparam logic [4:0] P_DIAG = 5'b00100;
    localparam logic [4:0] P_HALF = 5'b01000;
    localparam logic [4:0] P_ITER = 5'b10000;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    convolutor_index_gen_if #(.ADDR_W(5)) bus ();

    convolutor_index_gen #(.ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Assert the selected pulses for exactly one rising edge; returns at the next falling edge.
    task automatic pulse(input logic [4:0] m);
        bus.register_load_i   = m[0];
        bus.diag_size_i       = m[1];
        bus.diagonal_count_i  = m[2];
        bus.half_loop_load_i  = m[3];
        bus.iteration_count_i = m[4];
        @(negedge clk);
        bus.register_load_i   = 1'b0;
        bus.diag_size_i       = 1'b0;
        bus.diagonal_count_i  = 1'b0;
        bus.half_loop_load_i  = 1'b0;
        bus.iteration_count_i = 1'b0;
    endtask

    task automatic load_sizes(input size_t nx, input size_t ny);
        bus.size_x_i = nx;
        bus.size_y_i = ny;
        pulse(P_LOAD);
    endtask

    // Hand-derived (x, y, z) sequence for Nx=4, Ny=3.
    int ex_x [12] = '{0, 0, 1, 0, 1, 2, 1, 2, 3, 2, 3, 3};
    int ex_y [12] = '{0, 1, 0, 2, 1, 0, 2, 1, 0, 2, 1, 2};
    int ex_z [12] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 4, 4, 5};

    int n_prod;
    int n_diag;
    int guard;

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.register_load_i   = 1'b0;
        bus.diag_size_i       = 1'b0;
        bus.diagonal_count_i  = 1'b0;
        bus.half_loop_load_i  = 1'b0;
        bus.iteration_count_i = 1'b0;
        bus.size_x_i = '0;
        bus.size_y_i = '0;
        repeat (2) @(negedge clk);

        check("rst_half",     32'(bus.half_loop_o),     32'd0);
        check("rst_valid",    32'(bus.bounds_valid_o),  32'd0);
        check("rst_complete", 32'(bus.calc_complete_o), 32'd0);
        check("rst_zaddr",    32'(bus.z_addr_o),        32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Sizing: Nx=4, Ny=3 gives Nz=6, first diagonal not in the second half.
        load_sizes(6'd4, 6'd3);
        pulse(P_DSZ);
        check("sz_half",     32'(bus.half_loop_o),     32'd0);
        check("sz_complete", 32'(bus.calc_complete_o), 32'd0);
        check("sz_nz",       32'(dut.nz_q),            32'd6);

        // Full walk as the FSM would drive it.
        n_prod = 0;
        n_diag = 0;
        guard  = 0;
        while (!bus.calc_complete_o && guard < 80) begin
            pulse(P_HALF);
            guard++;
            if (bus.z_addr_o == 6'd2) check("walk_half_k2", 32'(bus.half_loop_o), 32'd0);
            if (bus.z_addr_o == 6'd3) check("walk_half_k3", 32'(bus.half_loop_o), 32'd1);
            while (bus.bounds_valid_o && guard < 80) begin
                if (n_prod < 12) begin
                    check($sformatf("walk_x%0d", n_prod), 32'(bus.x_addr_o), 32'(ex_x[n_prod]));
                    check($sformatf("walk_y%0d", n_prod), 32'(bus.y_addr_o), 32'(ex_y[n_prod]));
                    check($sformatf("walk_z%0d", n_prod), 32'(bus.z_addr_o), 32'(ex_z[n_prod]));
                end
                n_prod++;
                pulse(P_ITER);
                guard++;
            end
            pulse(P_DIAG);
            n_diag++;
            guard++;
        end
        check("walk_budget",   32'(guard < 80),          32'd1);
        check("walk_products", 32'(n_prod),              32'd12);
        check("walk_diags",    32'(n_diag),              32'd6);
        check("walk_complete", 32'(bus.calc_complete_o), 32'd1);
        @(negedge clk);
        check("done_hold",     32'(bus.calc_complete_o), 32'd1);

        // Single term.
        load_sizes(6'd1, 6'd1);
        pulse(P_DSZ);
        pulse(P_HALF);
        check("one_valid", 32'(bus.bounds_valid_o), 32'd1);
        check("one_x",     32'(bus.x_addr_o),       32'd0);
        check("one_y",     32'(bus.y_addr_o),       32'd0);
        check("one_z",     32'(bus.z_addr_o),       32'd0);
        pulse(P_ITER);
        check("one_iter_end", 32'(bus.bounds_valid_o), 32'd0);
        check("one_not_done", 32'(bus.calc_complete_o), 32'd0);
        pulse(P_DIAG);
        check("one_complete", 32'(bus.calc_complete_o), 32'd1);

        // Zero size completes immediately and never presents valid bounds.
        load_sizes(6'd0, 6'd5);
        pulse(P_DSZ);
        check("zero_complete", 32'(bus.calc_complete_o), 32'd1);
        check("zero_valid",    32'(bus.bounds_valid_o),  32'd0);
        pulse(P_HALF);
        check("zero_valid_ld", 32'(bus.bounds_valid_o),  32'd0);
        check("zero_done",     32'(bus.calc_complete_o), 32'd1);

        // Priority: diagonal_count beats iteration_count.
        load_sizes(6'd4, 6'd3);
        pulse(P_DSZ);
        repeat (3) pulse(P_DIAG);
        pulse(P_HALF);
        check("pri_pre_x", 32'(bus.x_addr_o), 32'd1);
        check("pri_pre_y", 32'(bus.y_addr_o), 32'd2);
        pulse(P_DIAG | P_ITER);
        check("pri_z",     32'(bus.z_addr_o),       32'd4);
        check("pri_x",     32'(bus.x_addr_o),       32'd1);
        check("pri_valid", 32'(bus.bounds_valid_o), 32'd0);
        pulse(P_HALF);
        check("pri_k4_x",  32'(bus.x_addr_o),       32'd2);

        // Asynchronous reset in the middle of diagonal k=3.
        load_sizes(6'd4, 6'd3);
        pulse(P_DSZ);
        repeat (3) pulse(P_DIAG);
        pulse(P_HALF);
        check("arst_pre_half",  32'(bus.half_loop_o),    32'd1);
        check("arst_pre_valid", 32'(bus.bounds_valid_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_half",     32'(bus.half_loop_o),     32'd0);
        check("arst_valid",    32'(bus.bounds_valid_o),  32'd0);
        check("arst_complete", 32'(bus.calc_complete_o), 32'd0);
        check("arst_x",        32'(bus.x_addr_o),        32'd0);
        check("arst_y",        32'(bus.y_addr_o),        32'd0);
        check("arst_z",        32'(bus.z_addr_o),        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_state", 32'(dut.state_q), 32'd0);
        pulse(P_DSZ);
        check("idle_dsz_ignored", 32'(bus.calc_complete_o), 32'd0);

        // Oversized X: clamp or wrap at the 5-bit address port.
        load_sizes(6'd40, 6'd1);
        pulse(P_DSZ);
        repeat (31) pulse(P_DIAG);
        pulse(P_HALF);
        check("big_k31_x",     32'(bus.x_addr_o),       32'd31);
        check("big_k31_y",     32'(bus.y_addr_o),       32'd0);
        check("big_k31_z",     32'(bus.z_addr_o),       32'd31);
        check("big_k31_valid", 32'(bus.bounds_valid_o), 32'd1);
        pulse(P_DIAG);
`ifdef CONVOLUTOR_SIZE_CLAMP_EN
        check("clamp_nx",       32'(dut.nx_q),            32'd32);
        check("clamp_complete", 32'(bus.calc_complete_o), 32'd1);
`else
        check("wrap_not_done", 32'(bus.calc_complete_o), 32'd0);
        pulse(P_HALF);
        check("wrap_x",     32'(bus.x_addr_o),       32'd0);
        check("wrap_z",     32'(bus.z_addr_o),       32'd32);
        check("wrap_valid", 32'(bus.bounds_valid_o), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
